// File: rtl/hs_sync_tx_if.sv
// Source-side signal bundle of the hs_sync_tx toggle handshake.
// master is the transmitter's view, slave is the producer/destination environment's view.
interface hs_sync_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] IN_DATA;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [BUS_WIDTH-1:0] TX_DATA;
  logic                 TX_REQ;
  logic                 TX_ACK;
  logic                 DONE;
  logic                 PROTO_ERR;

  modport master (
    input  IN_DATA, IN_VALID, TX_ACK,
    output IN_READY, TX_DATA, TX_REQ, DONE, PROTO_ERR
  );

  modport slave (
    output IN_DATA, IN_VALID, TX_ACK,
    input  IN_READY, TX_DATA, TX_REQ, DONE, PROTO_ERR
  );
endinterface

// File: rtl/hs_sync_tx.sv
// Source side of a toggle (two-phase) request/acknowledge clock-domain crossing.
// One word is in flight at a time; the returning ACK toggle is synchronized into CLK.
module hs_sync_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  hs_sync_tx_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [NUM_STAGES-1:0] ack_sync_r;
  logic                  ack_s;
  logic [BUS_WIDTH-1:0]  tx_data_r;
  logic [BUS_WIDTH-1:0]  tx_data_nxt_s;
  logic                  tx_req_r;
  logic                  tx_req_nxt_s;
  logic                  done_r;
  logic                  done_nxt_s;
  logic                  proto_err_r;
  logic                  proto_err_nxt_s;

  // Only the final synchronizer stage may be observed by any logic.
  assign ack_s = ack_sync_r[NUM_STAGES-1];

  // ACK synchronizer chain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[NUM_STAGES-2:0], bus.TX_ACK};
    end
  end

  // State and registered output storage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      tx_data_r   <= '0;
      tx_req_r    <= 1'b0;
      done_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_req_r    <= tx_req_nxt_s;
      done_r      <= done_nxt_s;
      proto_err_r <= proto_err_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.IN_VALID) begin
          state_nxt_s = WAIT_ACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_ACK: begin
        // Transfer completes once the synchronized ACK level catches up with REQ.
        if (ack_s == tx_req_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    tx_data_nxt_s   = tx_data_r;
    tx_req_nxt_s    = tx_req_r;
    done_nxt_s      = 1'b0;
    proto_err_nxt_s = proto_err_r;
    case (state_r)
      IDLE: begin
        if (bus.IN_VALID) begin
          tx_data_nxt_s = bus.IN_DATA;
          tx_req_nxt_s  = ~tx_req_r;
        end else begin
          tx_data_nxt_s = tx_data_r;
          tx_req_nxt_s  = tx_req_r;
        end
        // An ACK level differing from REQ while idle was never requested.
        if (ack_s != tx_req_r) begin
          proto_err_nxt_s = 1'b1;
        end else begin
          proto_err_nxt_s = proto_err_r;
        end
      end
      WAIT_ACK: begin
        if (ack_s == tx_req_r) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.IN_READY  = (state_r == IDLE);
  assign bus.TX_DATA   = tx_data_r;
  assign bus.TX_REQ    = tx_req_r;
  assign bus.DONE      = done_r;
  assign bus.PROTO_ERR = proto_err_r;

endmodule

// File: tb/tb_hs_sync_tx.sv
// Directed bench for hs_sync_tx (BUS_WIDTH=8, NUM_STAGES=2): a vector table plus
// hand-written sequences for back-to-back transfers, protocol error and mid-transfer reset.
module tb_hs_sync_tx;

  typedef struct {
    logic [7:0] in_data;
    logic       in_valid;
    logic       tx_ack;
    logic [7:0] e_data;
    logic       e_req;
    logic       e_ready;
    logic       e_done;
    logic       e_perr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [11];

  hs_sync_tx_if #(.BUS_WIDTH(8)) bus ();

  hs_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    bus.IN_DATA  = 8'h00;
    bus.IN_VALID = 1'b0;
    bus.TX_ACK   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] words [3];
    logic [3:0] hist;
    logic [7:0] cur;
    logic       exp_req;
    logic       take;
    int         acc;
    int         dones;
    int         done_at;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h5A, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values, asynchronously applied before any clock edge.
    rst          = 1'b1;
    bus.IN_DATA  = 8'h00;
    bus.IN_VALID = 1'b0;
    bus.TX_ACK   = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst tx_data",   {24'd0, bus.TX_DATA}, 32'h00);
    check("rst tx_req",    {31'd0, bus.TX_REQ},    32'd0);
    check("rst in_ready",  {31'd0, bus.IN_READY},  32'd1);
    check("rst done",      {31'd0, bus.DONE},      32'd0);
    check("rst proto_err", {31'd0, bus.PROTO_ERR}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single transfer, ACK latency, back-to-back acceptance in the DONE cycle.
    for (int i = 0; i < 11; i++) begin
      bus.IN_DATA  = vecs[i].in_data;
      bus.IN_VALID = vecs[i].in_valid;
      bus.TX_ACK   = vecs[i].tx_ack;
      step();
      check($sformatf("vec%0d tx_data", i),   {24'd0, bus.TX_DATA},   {24'd0, vecs[i].e_data});
      check($sformatf("vec%0d tx_req", i),    {31'd0, bus.TX_REQ},    {31'd0, vecs[i].e_req});
      check($sformatf("vec%0d in_ready", i),  {31'd0, bus.IN_READY},  {31'd0, vecs[i].e_ready});
      check($sformatf("vec%0d done", i),      {31'd0, bus.DONE},      {31'd0, vecs[i].e_done});
      check($sformatf("vec%0d proto_err", i), {31'd0, bus.PROTO_ERR}, {31'd0, vecs[i].e_perr});
    end

    // Three words with IN_VALID held high and a 4-cycle echoing responder.
    do_reset();
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    hist     = 4'b0000;
    exp_req  = 1'b0;
    cur      = 8'h00;
    acc      = 0;
    dones    = 0;
    for (int c = 0; c < 80 && dones < 3; c++) begin
      bus.IN_VALID = (acc < 3);
      bus.IN_DATA  = (acc < 3) ? words[acc] : 8'h00;
      bus.TX_ACK   = hist[3];
      take         = bus.IN_READY && bus.IN_VALID;
      step();
      hist = {hist[2:0], bus.TX_REQ};
      if (take) begin
        exp_req = ~exp_req;
        cur     = words[acc];
        acc++;
        check($sformatf("seq word%0d tx_data", acc), {24'd0, bus.TX_DATA}, {24'd0, cur});
        check($sformatf("seq word%0d tx_req", acc),  {31'd0, bus.TX_REQ},  {31'd0, exp_req});
      end else if (acc > 0) begin
        check("seq tx_data stable", {24'd0, bus.TX_DATA}, {24'd0, cur});
      end
      if (bus.DONE) begin
        dones++;
        check("seq in_ready at done", {31'd0, bus.IN_READY}, 32'd1);
      end
    end
    check("seq accepted", acc, 3);
    check("seq done pulses", dones, 3);

    // Unsolicited ACK toggle in IDLE, then a transfer with the error still sticky.
    do_reset();
    bus.TX_ACK = 1'b1;
    step();
    check("perr edge k", {31'd0, bus.PROTO_ERR}, 32'd0);
    step();
    check("perr edge k+1", {31'd0, bus.PROTO_ERR}, 32'd0);
    step();
    check("perr edge k+2", {31'd0, bus.PROTO_ERR}, 32'd1);
    check("perr idle ready", {31'd0, bus.IN_READY}, 32'd1);
    check("perr idle req", {31'd0, bus.TX_REQ}, 32'd0);
    bus.IN_DATA  = 8'h77;
    bus.IN_VALID = 1'b1;
    step();
    check("perr xfer tx_data", {24'd0, bus.TX_DATA}, 32'h77);
    check("perr xfer tx_req", {31'd0, bus.TX_REQ}, 32'd1);
    check("perr xfer sticky", {31'd0, bus.PROTO_ERR}, 32'd1);
    bus.IN_VALID = 1'b0;
    step();
    check("perr xfer done", {31'd0, bus.DONE}, 32'd1);
    check("perr after done", {31'd0, bus.PROTO_ERR}, 32'd1);

    // Reset in WAIT_ACK aborts the transfer; the first edge after release accepts.
    do_reset();
    bus.IN_DATA  = 8'h3C;
    bus.IN_VALID = 1'b1;
    step();
    check("abort tx_data", {24'd0, bus.TX_DATA}, 32'h3C);
    check("abort in_ready", {31'd0, bus.IN_READY}, 32'd0);
    bus.IN_VALID = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("abort rst tx_data",   {24'd0, bus.TX_DATA},   32'h00);
    check("abort rst tx_req",    {31'd0, bus.TX_REQ},    32'd0);
    check("abort rst in_ready",  {31'd0, bus.IN_READY},  32'd1);
    check("abort rst done",      {31'd0, bus.DONE},      32'd0);
    check("abort rst proto_err", {31'd0, bus.PROTO_ERR}, 32'd0);
    @(negedge clk);
    rst          = 1'b1;
    bus.IN_DATA  = 8'h42;
    bus.IN_VALID = 1'b1;
    step();
    check("first edge tx_data", {24'd0, bus.TX_DATA}, 32'h42);
    check("first edge tx_req",  {31'd0, bus.TX_REQ},  32'd1);
    check("first edge done",    {31'd0, bus.DONE},    32'd0);

    // IN_DATA churn during WAIT_ACK must not disturb TX_DATA.
    for (int j = 0; j < 4; j++) begin
      bus.IN_DATA = 8'h80 + 8'(j);
      step();
      check($sformatf("hold%0d tx_data", j),  {24'd0, bus.TX_DATA},  32'h42);
      check($sformatf("hold%0d in_ready", j), {31'd0, bus.IN_READY}, 32'd0);
    end
    bus.TX_ACK = 1'b1;
    done_at    = -1;
    for (int n = 0; n < 6 && done_at < 0; n++) begin
      step();
      if (bus.DONE) begin
        done_at = n;
        bus.IN_VALID = 1'b0;
        check("hold done in_ready", {31'd0, bus.IN_READY}, 32'd1);
      end
      check("hold tx_data till done", {24'd0, bus.TX_DATA}, 32'h42);
    end
    check("hold done latency", done_at, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_sync_tx.md
HS_SYNC_TX -- requirements
Module: hs_sync_tx

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of the transferred word.
REQ-002 Parameter NUM_STAGES, default 2: flip-flop depth of the internal ACK synchronizer; legal range 2..4.
REQ-003 CLK  input  1  source-domain clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 IN_DATA  input  BUS_WIDTH  word offered by the source-domain producer.
REQ-006 IN_VALID  input  1  producer qualifier for IN_DATA.
REQ-007 IN_READY  output  1  block can accept a word this cycle.
REQ-008 TX_DATA  output  BUS_WIDTH  registered word driven across the domain boundary.
REQ-009 TX_REQ  output  1  registered request toggle; each level change announces a new TX_DATA.
REQ-010 TX_ACK  input  1  acknowledge toggle from the destination domain, asynchronous to CLK.
REQ-011 DONE  output  1  one-cycle pulse marking completion of a transfer.
REQ-012 PROTO_ERR  output  1  sticky flag for an unsolicited ACK toggle.

Function
REQ-013 The block SHALL contain exactly two states, IDLE and WAIT_ACK.
REQ-014 TX_ACK SHALL pass through a NUM_STAGES-deep flip-flop chain; only the last stage (ack_s) SHALL be used by any logic.
REQ-015 IN_READY SHALL be decoded from the state register: 1 in IDLE, 0 in WAIT_ACK, with no combinational path from IN_VALID or TX_ACK.
REQ-016 IDLE, IN_VALID=1, rising edge: TX_DATA<=IN_DATA, TX_REQ<=~TX_REQ, state->WAIT_ACK.
REQ-017 IDLE, IN_VALID=0: TX_DATA, TX_REQ and state SHALL hold.
REQ-018 WAIT_ACK: TX_DATA and TX_REQ SHALL be held stable; IN_DATA and IN_VALID SHALL be ignored.
REQ-019 WAIT_ACK with ack_s==TX_REQ at a rising edge: state->IDLE, and DONE SHALL be 1 for exactly the following cycle.
REQ-020 In the cycle DONE=1, IN_READY SHALL be 1; a word offered with IN_VALID=1 in that cycle SHALL be accepted (back-to-back transfers).
REQ-021 Latency: the first TX_ACK toggle sampled at edge k SHALL produce ack_s at edge k+NUM_STAGES-1, state IDLE and DONE=1 after edge k+NUM_STAGES.
REQ-022 IDLE with ack_s!=TX_REQ at a rising edge SHALL set PROTO_ERR=1, held until reset; the state SHALL NOT change.
REQ-023 TX_REQ wrap-around is inherent: the toggle has no count, and any number of transfers SHALL be supported.
REQ-024 TX_ACK glitches or toggles while in WAIT_ACK with ack_s!=TX_REQ SHALL have no effect.

Reset
REQ-025 RST=0 SHALL immediately force: state IDLE, TX_DATA=0, TX_REQ=0, all ACK synchronizer stages=0, DONE=0, PROTO_ERR=0, IN_READY=1.
REQ-026 RST asserted in WAIT_ACK SHALL abort the transfer with no DONE pulse; the destination side is reset by the same system reset.
REQ-027 The first rising edge after RST deasserts SHALL be able to accept a word.

Verification
REQ-028 Reset, then IN_DATA=0xA5, IN_VALID=1 for one cycle -> TX_DATA=0xA5, TX_REQ=1, IN_READY=0 on the next cycle.
REQ-029 Continuing REQ-028, toggle TX_ACK to 1 three cycles later, with NUM_STAGES=2 -> DONE high for exactly one cycle, 2 edges after the sampling edge; IN_READY=1 in the same cycle.
REQ-030 Words 0x01, 0x02, 0x03 offered with IN_VALID held high and a responder model echoing TX_REQ to TX_ACK after 4 cycles -> three DONE pulses, TX_REQ sequence 1,0,1, each word stable on TX_DATA until its DONE.
REQ-031 In IDLE with TX_REQ=0, toggle TX_ACK to 1 -> PROTO_ERR=1 NUM_STAGES edges later, state stays IDLE, and PROTO_ERR stays 1 through later transfers.
REQ-032 Assert RST mid-WAIT_ACK, IN_DATA=0x3C -> all outputs at reset values immediately, no DONE pulse, IN_READY=1.
REQ-033 In WAIT_ACK, change IN_DATA every cycle -> TX_DATA unchanged until DONE.
